// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// the load/store stage. Data has fixed priority. A wait counter stops fetch
// from starving. All outputs are registered.
// Ports: arbiter_clock_in/arbiter_reset_in (sync, active-low), arbiter_flush_in,
//   fetch req (ins_valid/addr -> ins_ready/data), data req (data_valid/we/
//   addr/wdata -> data_ready/rdata), memory port (mem_valid/we/addr/wdata <-
//   mem_ready/rdata), arbiter_busy_out.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            arbiter_clock_in,
    input  logic            arbiter_reset_in,
    input  logic            arbiter_flush_in,
    input  logic            arbiter_ins_valid_in,
    input  logic [XLEN-1:0] arbiter_ins_addr_in,
    output logic            arbiter_ins_ready_out,
    output logic [XLEN-1:0] arbiter_ins_data_out,
    input  logic            arbiter_data_valid_in,
    input  logic            arbiter_data_we_in,
    input  logic [XLEN-1:0] arbiter_data_addr_in,
    input  logic [XLEN-1:0] arbiter_data_wdata_in,
    output logic            arbiter_data_ready_out,
    output logic [XLEN-1:0] arbiter_data_rdata_out,
    output logic            arbiter_mem_valid_out,
    output logic            arbiter_mem_we_out,
    output logic [XLEN-1:0] arbiter_mem_addr_out,
    output logic [XLEN-1:0] arbiter_mem_wdata_out,
    input  logic            arbiter_mem_ready_in,
    input  logic [XLEN-1:0] arbiter_mem_rdata_in,
    output logic            arbiter_busy_out
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        INS_BUSY,
        DATA_BUSY
    } state_e;

    state_e          state_q, state_d;
    logic            mem_valid_q, mem_valid_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic            ins_ready_q, ins_ready_d;
    logic [XLEN-1:0] ins_data_q, ins_data_d;
    logic            data_ready_q, data_ready_d;
    logic [XLEN-1:0] data_rdata_q, data_rdata_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            drop_q, drop_d;

    logic ins_elig, data_elig, ins_grant;

    // A requester whose ready pulse is high this cycle still shows the old
    // valid; skipping it avoids granting the finished request twice.
    assign ins_elig  = arbiter_ins_valid_in & ~ins_ready_q & ~arbiter_flush_in;
    assign data_elig = arbiter_data_valid_in & ~data_ready_q;

    always_comb begin
        state_d      = state_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ins_ready_d  = 1'b0;
        ins_data_d   = ins_data_q;
        data_ready_d = 1'b0;
        data_rdata_d = data_rdata_q;
        drop_d       = drop_q;
        ins_grant    = 1'b0;

        case (state_q)
            IDLE: begin
                if (ins_elig && (!data_elig || wait_cnt_q == LIMIT)) begin
                    ins_grant   = 1'b1;
                    state_d     = INS_BUSY;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = arbiter_ins_addr_in;
                    mem_wdata_d = '0;
                end else if (data_elig) begin
                    state_d     = DATA_BUSY;
                    mem_valid_d = 1'b1;
                    mem_we_d    = arbiter_data_we_in;
                    mem_addr_d  = arbiter_data_addr_in;
                    mem_wdata_d = arbiter_data_wdata_in;
                end
            end
            INS_BUSY: begin
                if (arbiter_mem_ready_in) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    drop_d      = 1'b0;
                    // A flush in the completing cycle also drops the word.
                    if (!(drop_q || arbiter_flush_in)) begin
                        ins_ready_d = 1'b1;
                        ins_data_d  = arbiter_mem_rdata_in;
                    end
                end else if (arbiter_flush_in) begin
                    drop_d = 1'b1;
                end
            end
            DATA_BUSY: begin
                if (arbiter_mem_ready_in) begin
                    state_d      = IDLE;
                    mem_valid_d  = 1'b0;
                    data_ready_d = 1'b1;
                    if (!mem_we_q) begin
                        data_rdata_d = arbiter_mem_rdata_in;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase

        if (!arbiter_ins_valid_in || arbiter_flush_in || ins_grant) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge arbiter_clock_in) begin
        if (!arbiter_reset_in) begin
            state_q      <= IDLE;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ins_ready_q  <= 1'b0;
            ins_data_q   <= '0;
            data_ready_q <= 1'b0;
            data_rdata_q <= '0;
            wait_cnt_q   <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ins_ready_q  <= ins_ready_d;
            ins_data_q   <= ins_data_d;
            data_ready_q <= data_ready_d;
            data_rdata_q <= data_rdata_d;
            wait_cnt_q   <= wait_cnt_d;
            drop_q       <= drop_d;
        end
    end

    assign arbiter_ins_ready_out  = ins_ready_q;
    assign arbiter_ins_data_out   = ins_data_q;
    assign arbiter_data_ready_out = data_ready_q;
    assign arbiter_data_rdata_out = data_rdata_q;
    assign arbiter_mem_valid_out  = mem_valid_q;
    assign arbiter_mem_we_out     = mem_we_q;
    assign arbiter_mem_addr_out   = mem_addr_q;
    assign arbiter_mem_wdata_out  = mem_wdata_q;
    assign arbiter_busy_out       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic, all
// checked each cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            ins_valid = 1'b0;
    logic [XLEN-1:0] ins_addr = '0;
    logic            ins_ready;
    logic [XLEN-1:0] ins_data;
    logic            data_valid = 1'b0;
    logic            data_we = 1'b0;
    logic [XLEN-1:0] data_addr = '0;
    logic [XLEN-1:0] data_wdata = '0;
    logic            data_ready;
    logic [XLEN-1:0] data_rdata;
    logic            mem_valid;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;
    logic            busy;

    int n_chk = 0;
    int n_fail = 0;
    int lat = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .arbiter_clock_in       (clk),
        .arbiter_reset_in       (rst),
        .arbiter_flush_in       (flush),
        .arbiter_ins_valid_in   (ins_valid),
        .arbiter_ins_addr_in    (ins_addr),
        .arbiter_ins_ready_out  (ins_ready),
        .arbiter_ins_data_out   (ins_data),
        .arbiter_data_valid_in  (data_valid),
        .arbiter_data_we_in     (data_we),
        .arbiter_data_addr_in   (data_addr),
        .arbiter_data_wdata_in  (data_wdata),
        .arbiter_data_ready_out (data_ready),
        .arbiter_data_rdata_out (data_rdata),
        .arbiter_mem_valid_out  (mem_valid),
        .arbiter_mem_we_out     (mem_we),
        .arbiter_mem_addr_out   (mem_addr),
        .arbiter_mem_wdata_out  (mem_wdata),
        .arbiter_mem_ready_in   (mem_ready),
        .arbiter_mem_rdata_in   (mem_rdata),
        .arbiter_busy_out       (busy)
    );

    // Model: who owns the port (0 none, 1 fetch, 2 data) plus the visible
    // values each output must show.
    int              owner = 0;
    int              waited = 0;
    bit              dropped = 0;
    logic            e_mv = 0, e_we = 0, e_ir = 0, e_dr = 0;
    logic [XLEN-1:0] e_addr = '0, e_wd = '0, e_id = '0, e_rd = '0;

    task automatic chk(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_step();
        bit fetch_ok, data_ok, fetch_got;
        fetch_got = 0;
        if (!rst) begin
            owner = 0; waited = 0; dropped = 0;
            e_mv = 0; e_we = 0; e_ir = 0; e_dr = 0;
            e_addr = '0; e_wd = '0; e_id = '0; e_rd = '0;
            return;
        end
        fetch_ok = ins_valid && !e_ir && !flush;
        data_ok  = data_valid && !e_dr;
        e_ir = 0;
        e_dr = 0;
        if (owner == 0) begin
            if (fetch_ok && (!data_ok || waited == LIMIT)) begin
                owner = 1; fetch_got = 1;
                e_mv = 1; e_we = 0; e_addr = ins_addr; e_wd = '0;
            end else if (data_ok) begin
                owner = 2;
                e_mv = 1; e_we = data_we; e_addr = data_addr; e_wd = data_wdata;
            end
        end else if (mem_ready) begin
            if (owner == 1) begin
                if (!dropped && !flush) begin
                    e_ir = 1; e_id = mem_rdata;
                end
            end else begin
                e_dr = 1;
                if (!e_we) e_rd = mem_rdata;
            end
            owner = 0; e_mv = 0; dropped = 0;
        end else if (owner == 1 && flush) begin
            dropped = 1;
        end
        if (!ins_valid || flush || fetch_got) waited = 0;
        else if (waited < LIMIT) waited++;
    endtask

    task automatic compare_all();
        chk("mem_valid", mem_valid, e_mv);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("ins_ready", ins_ready, e_ir);
        chk("ins_data", ins_data, e_id);
        chk("data_ready", data_ready, e_dr);
        chk("data_rdata", data_rdata, e_rd);
        chk("busy", busy, owner != 0);
    endtask

    // Inputs are set by the caller at a negedge; the model predicts the
    // edge, then outputs are compared at the following negedge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic mem_auto();
        mem_rdata = $urandom;
        if (mem_valid && !mem_ready) begin
            if (lat == 0) begin
                mem_ready = 1;
                lat = $urandom_range(0, 2);
            end else begin
                lat--;
                mem_ready = 0;
            end
        end else begin
            mem_ready = 0;
        end
    endtask

    initial begin
        bit got;
        @(negedge clk);
        // Reset held with both requests pending.
        rst = 0; ins_valid = 1; ins_addr = 32'h100;
        data_valid = 1; data_we = 0; data_addr = 32'h40;
        cycle();
        cycle();
        chk("rst_busy", busy, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_ins_ready", ins_ready, 0);
        rst = 1;
        cycle();
        chk("first_grant_data", mem_addr, 32'h40);
        chk("first_grant_valid", mem_valid, 1);
        mem_ready = 1; mem_rdata = 32'h1234;
        cycle();
        chk("load_ready", data_ready, 1);
        chk("load_rdata", data_rdata, 32'h1234);
        data_valid = 0; mem_ready = 0;
        cycle();
        chk("fetch_addr", mem_addr, 32'h100);
        chk("fetch_we", mem_we, 0);
        cycle();
        chk("fetch_hold", mem_valid, 1);
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        cycle();
        chk("fetch_ready", ins_ready, 1);
        chk("fetch_data", ins_data, 32'hDEADBEEF);
        ins_valid = 0; mem_ready = 0;
        cycle();
        chk("fetch_pulse_once", ins_ready, 0);

        // Store keeps the previous load data.
        data_valid = 1; data_we = 1; data_addr = 32'h20; data_wdata = 32'h55;
        cycle();
        chk("store_we", mem_we, 1);
        chk("store_wdata", mem_wdata, 32'h55);
        mem_ready = 1; mem_rdata = 32'h999;
        cycle();
        chk("store_ready", data_ready, 1);
        chk("store_rdata_kept", data_rdata, 32'h1234);
        data_valid = 0; data_we = 0; mem_ready = 0;
        cycle();

        // Flush mid-fetch: response dropped, retry served normally.
        ins_valid = 1; ins_addr = 32'h400;
        cycle();
        flush = 1;
        cycle();
        flush = 0; mem_ready = 1; mem_rdata = 32'hBAD;
        cycle();
        chk("flush_no_ready", ins_ready, 0);
        chk("flush_data_kept", ins_data, 32'hDEADBEEF);
        mem_ready = 0;
        cycle();
        chk("refetch_addr", mem_addr, 32'h400);
        mem_ready = 1; mem_rdata = 32'hCAFE;
        cycle();
        chk("refetch_data", ins_data, 32'hCAFE);
        chk("refetch_ready", ins_ready, 1);
        ins_valid = 0; mem_ready = 0;
        cycle();

        // Reset during a data access.
        data_valid = 1; data_addr = 32'h80;
        cycle();
        rst = 0;
        cycle();
        chk("midrst_valid", mem_valid, 0);
        chk("midrst_busy", busy, 0);
        rst = 1; data_valid = 0;
        cycle();
        chk("midrst_no_ready", data_ready, 0);

        // Contention: fetch must get the port while data keeps requesting.
        ins_valid = 1; ins_addr = 32'h200;
        data_valid = 1; data_addr = 32'h300; lat = 0;
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            mem_auto();
            cycle();
            if (mem_valid && mem_addr == 32'h200) got = 1;
        end
        chk("starve_fetch_grant", got, 1);
        rst = 0; ins_valid = 0; data_valid = 0; mem_ready = 0;
        cycle();
        rst = 1;

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 9) == 0);
            if (!ins_valid || ins_ready || flush) begin
                ins_valid = ($urandom_range(0, 2) != 0);
                ins_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!data_valid || data_ready) begin
                data_valid = ($urandom_range(0, 2) != 0);
                data_we = $urandom_range(0, 1);
                data_addr = $urandom & 32'hFFFF_FFFC;
                data_wdata = $urandom;
            end
            mem_auto();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
